inst_rom_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the instruction ROM read port. It sits between the ROM and two clients: port 0, the pipeline IF stage, and port 1, the debug/trace reader. Each client gets a valid/ready request channel and a registered response channel. Port 0 normally has priority, and an anti-starvation counter bounds how long port 1 can wait.

---
 rtl/inst_rom_arbiter_if.sv | 36 +++
 rtl/inst_rom_arbiter.sv | 105 ++++++++++
 tb/tb_inst_rom_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_arbiter_if.sv
// Client-side request/response channels of the two-port instruction ROM arbiter.
// slave is the arbiter side, master is the client side.
interface inst_rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req_valid;
    logic [ADDR_W-1:0] p0_req_addr;
    logic              p0_req_ready;
    logic              p0_rsp_valid;
    logic              p0_rsp_ready;
    logic [DATA_W-1:0] p0_rsp_data;
    logic              p0_rsp_err;

    logic              p1_req_valid;
    logic [ADDR_W-1:0] p1_req_addr;
    logic              p1_req_ready;
    logic              p1_rsp_valid;
    logic              p1_rsp_ready;
    logic [DATA_W-1:0] p1_rsp_data;
    logic              p1_rsp_err;

    modport slave (
        input  p0_req_valid, p0_req_addr, p0_rsp_ready,
        input  p1_req_valid, p1_req_addr, p1_rsp_ready,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data, p0_rsp_err,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data, p1_rsp_err
    );

    modport master (
        output p0_req_valid, p0_req_addr, p0_rsp_ready,
        output p1_req_valid, p1_req_addr, p1_rsp_ready,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data, p0_rsp_err,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data, p1_rsp_err
    );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter for the instruction ROM read port: IF stage (port 0) has
// priority, the debug reader (port 1) is forced through after MAX_WAIT losses.
module inst_rom_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_rom_arbiter_if.slave bus,
    output logic              rom_re,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY0  = 2'b01,
        BUSY1  = 2'b10,
        BUSY01 = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic              err0_q, err0_d, err1_q, err1_d;

    logic              held0, held1, elig0, elig1, gnt0, gnt1;
    logic              keep0, keep1, mis;
    logic [ADDR_W-1:0] gaddr;

    assign held0 = (state_q == BUSY0) || (state_q == BUSY01);
    assign held1 = (state_q == BUSY1) || (state_q == BUSY01);

    // Gating with rst_n keeps ready/rom_re low for the whole reset window.
    assign elig0 = rst_n && bus.p0_req_valid && (!held0 || bus.p0_rsp_ready);
    assign elig1 = rst_n && bus.p1_req_valid && (!held1 || bus.p1_rsp_ready);
    assign gnt1  = elig1 && (!elig0 || (wait_q == 4'(MAX_WAIT)));
    assign gnt0  = elig0 && !gnt1;

    assign gaddr = gnt1 ? bus.p1_req_addr : bus.p0_req_addr;
    assign mis   = (gaddr[1:0] != 2'b00);

    assign rom_re   = gnt0 || gnt1;
    assign rom_addr = rom_re ? gaddr : '0;

    assign bus.p0_req_ready = gnt0;
    assign bus.p1_req_ready = gnt1;
    assign bus.p0_rsp_valid = held0;
    assign bus.p1_rsp_valid = held1;
    assign bus.p0_rsp_data  = data0_q;
    assign bus.p1_rsp_data  = data1_q;
    assign bus.p0_rsp_err   = err0_q;
    assign bus.p1_rsp_err   = err1_q;

    always_comb begin
        keep0   = gnt0 || (held0 && !bus.p0_rsp_ready);
        keep1   = gnt1 || (held1 && !bus.p1_rsp_ready);
        state_d = state_q;
        unique case ({keep1, keep0})
            2'b00: state_d = IDLE;
            2'b01: state_d = BUSY0;
            2'b10: state_d = BUSY1;
            2'b11: state_d = BUSY01;
            default: state_d = IDLE;
        endcase

        data0_d = data0_q;
        err0_d  = err0_q;
        data1_d = data1_q;
        err1_d  = err1_q;
        if (gnt0) begin
            data0_d = mis ? '0 : rom_inst;
            err0_d  = mis;
        end
        if (gnt1) begin
            data1_d = mis ? '0 : rom_inst;
            err1_d  = mis;
        end

        wait_d = wait_q;
        if (gnt1 || !bus.p1_req_valid) begin
            wait_d = '0;
        end else if (elig1 && gnt0 && (wait_q < 4'(MAX_WAIT))) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            data0_q <= '0;
            data1_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Scoreboard bench for inst_rom_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_inst_rom_arbiter;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rom_re;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] mem [64];

    int checks = 0;
    int failures = 0;
    int g0cnt = 0;
    int g1cnt = 0;

    inst_rom_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .rom_re   (rom_re),
        .rom_addr (rom_addr),
        .rom_inst (rom_inst)
    );

    always #5 clk = ~clk;

    assign rom_inst = rom_re ? mem[rom_addr[7:2]] : 32'h0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [32:0] expv(input logic [31:0] a);
        if (a[1:0] != 2'b00) return {1'b1, 32'h0};
        return {1'b0, mem[a[7:2]]};
    endfunction

    // Reference model: which port holds a response, and the wait counter
    bit         m_held0, m_held1;
    int         m_wait;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_held0 = 0;
            m_held1 = 0;
            m_wait  = 0;
            q0.delete();
            q1.delete();
        end else begin
            bit e0, e1, x0, x1;
            logic [31:0] ea;
            e0 = bus.p0_req_valid && (!m_held0 || bus.p0_rsp_ready);
            e1 = bus.p1_req_valid && (!m_held1 || bus.p1_rsp_ready);
            x1 = e1 && (!e0 || m_wait == MAXW);
            x0 = e0 && !x1;
            ea = x1 ? bus.p1_req_addr : (x0 ? bus.p0_req_addr : 32'h0);
            chk("p0_req_ready", 64'(bus.p0_req_ready), 64'(x0));
            chk("p1_req_ready", 64'(bus.p1_req_ready), 64'(x1));
            chk("rom_re", 64'(rom_re), 64'(x0 | x1));
            chk("rom_addr", 64'(rom_addr), 64'(ea));
            if (x0) begin
                q0.push_back(expv(bus.p0_req_addr));
                g0cnt++;
            end
            if (x1) begin
                q1.push_back(expv(bus.p1_req_addr));
                g1cnt++;
            end
            if (x1 || !bus.p1_req_valid) m_wait = 0;
            else if (e1 && x0 && m_wait < MAXW) m_wait++;
            m_held0 = x0 ? 1'b1 : (bus.p0_rsp_ready ? 1'b0 : m_held0);
            m_held1 = x1 ? 1'b1 : (bus.p1_rsp_ready ? 1'b0 : m_held1);
        end
    end

    // Monitor: pops one expected response per consumed DUT response
    always @(negedge clk) begin
        if (rst_n) begin
            chk("p0_rsp_valid", 64'(bus.p0_rsp_valid), 64'(m_held0));
            chk("p1_rsp_valid", 64'(bus.p1_rsp_valid), 64'(m_held1));
            if (bus.p0_rsp_valid && bus.p0_rsp_ready) begin
                if (q0.size() == 0) chk("p0_unexpected_rsp", 64'(1), 64'(0));
                else chk("p0_rsp", 64'({bus.p0_rsp_err, bus.p0_rsp_data}),
                         64'(q0.pop_front()));
            end
            if (bus.p1_rsp_valid && bus.p1_rsp_ready) begin
                if (q1.size() == 0) chk("p1_unexpected_rsp", 64'(1), 64'(0));
                else chk("p1_rsp", 64'({bus.p1_rsp_err, bus.p1_rsp_data}),
                         64'(q1.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v0, input logic [31:0] a0, input logic r0,
                       input logic v1, input logic [31:0] a1, input logic r1);
        bus.p0_req_valid = v0;
        bus.p0_req_addr  = a0;
        bus.p0_rsp_ready = r0;
        bus.p1_req_valid = v1;
        bus.p1_req_addr  = a1;
        bus.p1_rsp_ready = r1;
    endtask

    initial begin
        logic [31:0] saved;
        bit acc0, acc1;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        // Reset with valids high: nothing may be granted or held
        drv(1, 32'h4, 1, 1, 32'h8, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("rst_p0_ready", 64'(bus.p0_req_ready), 0);
        chk("rst_p1_ready", 64'(bus.p1_req_ready), 0);
        chk("rst_rom_re", 64'(rom_re), 0);
        chk("rst_rsp", 64'({bus.p0_rsp_valid, bus.p0_rsp_err, bus.p0_rsp_data,
                            bus.p1_rsp_valid, bus.p1_rsp_err}), 0);
        chk("rst_p1_data", 64'(bus.p1_rsp_data), 0);
        drv(0, 0, 1, 0, 0, 1);
        rst_n = 1'b1;
        cyc();
        chk("idle_rom_re", 64'(rom_re), 0);
        chk("idle_rsp", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 0);

        // Single-port streaming
        drv(1, 32'h0, 1, 0, 0, 1);
        cyc();
        chk("stream_rsp0", 64'(bus.p0_rsp_data), 64'(mem[0]));
        bus.p0_req_addr = 32'h4;
        cyc();
        chk("stream_rsp1", 64'(bus.p0_rsp_data), 64'(mem[1]));
        bus.p0_req_addr = 32'h8;
        cyc();
        chk("stream_rsp2", 64'(bus.p0_rsp_data), 64'(mem[2]));
        bus.p0_req_valid = 1'b0;
        cyc();

        // Contention: p0 x4 then p1 x1
        drv(1, 32'h10, 1, 1, 32'h20, 1);
        g0cnt = 0;
        g1cnt = 0;
        repeat (20) cyc();
        chk("cont_p1_grants", 64'(g1cnt), 4);
        chk("cont_p0_grants", 64'(g0cnt), 16);

        // Back-pressure on p0; p1 must flow every cycle
        bus.p0_rsp_ready = 1'b0;
        repeat (2) cyc();
        saved = bus.p0_rsp_data;
        g1cnt = 0;
        repeat (6) cyc();
        chk("bp_p1_grants", 64'(g1cnt), 6);
        chk("bp_p0_hold", 64'(bus.p0_rsp_data), 64'(saved));
        bus.p0_rsp_ready = 1'b1;
        g0cnt = 0;
        cyc();
        chk("bp_release_p0", 64'(g0cnt), 1);

        // Misaligned p1 request
        drv(0, 0, 1, 1, 32'h6, 1);
        cyc();
        chk("mis_err", 64'({bus.p1_rsp_valid, bus.p1_rsp_err}), 64'(2'b11));
        chk("mis_data", 64'(bus.p1_rsp_data), 0);
        bus.p1_req_valid = 1'b0;
        cyc();

        // Random traffic honouring hold-until-ready
        drv(0, 0, 1, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc0 = bus.p0_req_valid && bus.p0_req_ready;
            acc1 = bus.p1_req_valid && bus.p1_req_ready;
            @(posedge clk);
            #1;
            if (!bus.p0_req_valid || acc0) begin
                bus.p0_req_valid = ($urandom_range(0, 3) != 0);
                bus.p0_req_addr  = {24'h0, 6'($urandom), 
                                    ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
            end
            if (!bus.p1_req_valid || acc1) begin
                bus.p1_req_valid = ($urandom_range(0, 2) != 0);
                bus.p1_req_addr  = {24'h0, 6'($urandom),
                                    ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00};
            end
            bus.p0_rsp_ready = ($urandom_range(0, 9) < 7);
            bus.p1_rsp_ready = ($urandom_range(0, 9) < 6);
        end

        // Fill both response registers, then reset asynchronously
        drv(1, 32'h30, 0, 1, 32'h34, 0);
        repeat (3) cyc();
        chk("pre_rst_full", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 64'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 0);
        chk("async_rst_ready", 64'({bus.p0_req_ready, bus.p1_req_ready, rom_re}), 0);
        drv(0, 0, 1, 0, 0, 1);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (4) cyc();
        chk("post_rst_valid", 64'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 0);
        chk("queues_empty", 64'(q0.size() + q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
